// File: rtl/instruction_fetch_unit.sv
// IF stage: word PC driving a combinational instruction memory, plus the IF/ID register
// handed to decode over a valid/ready handshake, with redirect, wrap-around and sticky halt.
module instruction_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           MEM_DEPTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]            HALT_OPCODE = 6'b111111
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_instr,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  id_ready,
    output logic                  if_id_valid,
    output logic [31:0]           if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic                  halted,
    output logic [31:0]           instr_count
);

    localparam int unsigned           IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHalted
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  slot_free;
    logic                  accept;
    logic                  is_halt;
    logic                  unused_target;

    always_comb begin
        slot_free   = !if_id_valid || id_ready;
        accept      = if_id_valid && id_ready && !redirect_valid;
        next_pc     = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_WIDTH'(1);
        // Targets outside the memory fold back into it by dropping the upper bits.
        redirect_pc = ADDR_WIDTH'(redirect_target[IDX_W-1:0]);
        is_halt     = (imem_instr[31:26] == HALT_OPCODE);
    end

    assign unused_target = ^redirect_target[ADDR_WIDTH-1:IDX_W];
    assign imem_addr     = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (accept) begin
                instr_count <= instr_count + 32'd1;
            end

            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                end
                StFetch: begin
                    if (redirect_valid) begin
                        pc_q        <= redirect_pc;
                        if_id_valid <= 1'b0;
                    end else if (slot_free) begin
                        if_id_instr <= imem_instr;
                        if_id_pc    <= pc_q;
                        if_id_valid <= 1'b1;
                        pc_q        <= next_pc;
                        // The halt word itself is still delivered to decode.
                        if (is_halt) begin
                            halted  <= 1'b1;
                            state_q <= StHalted;
                        end
                    end
                end
                StHalted: begin
                    if (id_ready) begin
                        if_id_valid <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 16-word combinational memory model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        halted;
    logic [31:0] instr_count;

    logic [31:0] mem [16];
    int          checks;
    int          failures;

    instruction_fetch_unit #(
        .ADDR_WIDTH  (32),
        .MEM_DEPTH   (16),
        .RESET_PC    (32'd0),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_ready        (id_ready),
        .if_id_valid     (if_id_valid),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .halted          (halted),
        .instr_count     (instr_count)
    );

    assign imem_instr = mem[imem_addr[3:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [31:0] ipc,
                             input logic [31:0] ins, input logic [31:0] pc,
                             input logic [31:0] cnt, input logic h);
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
        chk({tag, ".if_id_pc"}, if_id_pc, ipc);
        chk({tag, ".instr"}, if_id_instr, ins);
        chk({tag, ".pc"}, imem_addr, pc);
        chk({tag, ".count"}, instr_count, cnt);
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        for (int k = 0; k < 16; k++) mem[k] = 32'(k + 1);
        rst_n           = 1'b0;
        id_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;

        // Reset state
        #2;
        chk_state("reset", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        // Test 1: one idle cycle, then sequential delivery
        tick();
        chk_state("idle", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk_state("seq0", 1'b1, 32'd0, 32'd1, 32'd1, 32'd0, 1'b0);
        tick();
        chk_state("seq1", 1'b1, 32'd1, 32'd2, 32'd2, 32'd1, 1'b0);
        tick();
        chk_state("seq2", 1'b1, 32'd2, 32'd3, 32'd3, 32'd2, 1'b0);
        tick();
        chk_state("seq3", 1'b1, 32'd3, 32'd4, 32'd4, 32'd3, 1'b0);
        tick();
        tick();
        chk_state("seq5", 1'b1, 32'd5, 32'd6, 32'd6, 32'd5, 1'b0);

        // Test 2: four-cycle stall at if_id_pc=5
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_state("stall", 1'b1, 32'd5, 32'd6, 32'd6, 32'd5, 1'b0);
        end
        id_ready = 1'b1;
        tick();
        chk_state("release", 1'b1, 32'd6, 32'd7, 32'd7, 32'd6, 1'b0);

        // Test 3: wrap from 15 to 0, then out-of-range redirect folds to 2
        for (int i = 0; i < 9; i++) tick();
        chk_state("pc15", 1'b1, 32'd15, 32'd16, 32'd0, 32'd15, 1'b0);
        tick();
        chk_state("wrap0", 1'b1, 32'd0, 32'd1, 32'd1, 32'd16, 1'b0);
        redirect_valid  = 1'b1;
        redirect_target = 32'd18;
        tick();
        chk_state("redir18", 1'b0, 32'd0, 32'd1, 32'd2, 32'd16, 1'b0);
        redirect_valid = 1'b0;
        tick();
        chk_state("after18", 1'b1, 32'd2, 32'd3, 32'd3, 32'd16, 1'b0);

        // Test 4: redirect while stalled flushes the live entry
        id_ready        = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'd8;
        tick();
        chk_state("redir8", 1'b0, 32'd2, 32'd3, 32'd8, 32'd16, 1'b0);
        redirect_valid = 1'b0;
        tick();
        chk_state("after8", 1'b1, 32'd8, 32'd9, 32'd9, 32'd16, 1'b0);

        // Test 5: halt opcode at word 4
        mem[4]          = 32'hFC00_0123;
        id_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'd4;
        tick();
        chk_state("redir4", 1'b0, 32'd8, 32'd9, 32'd4, 32'd16, 1'b0);
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        tick();
        chk_state("halt", 1'b1, 32'd4, 32'hFC00_0123, 32'd5, 32'd16, 1'b1);
        redirect_valid  = 1'b1;
        redirect_target = 32'd10;
        tick();
        chk_state("halt_redir", 1'b1, 32'd4, 32'hFC00_0123, 32'd5, 32'd16, 1'b1);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        tick();
        chk_state("halt_drain", 1'b0, 32'd4, 32'hFC00_0123, 32'd5, 32'd17, 1'b1);
        tick();
        chk_state("halt_sticky", 1'b0, 32'd4, 32'hFC00_0123, 32'd5, 32'd17, 1'b1);

        // Async reset between edges clears a halted core immediately
        #2 rst_n = 1'b0;
        #1;
        chk_state("rst_halted", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        #2 rst_n = 1'b1;
        mem[4] = 32'd5;

        // Test 6: reset pulse mid-stall
        tick();
        tick();
        chk_state("r2_cap0", 1'b1, 32'd0, 32'd1, 32'd1, 32'd0, 1'b0);
        id_ready = 1'b0;
        tick();
        tick();
        chk_state("r2_stall", 1'b1, 32'd0, 32'd1, 32'd1, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_state("rst_stall", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        #2 rst_n = 1'b1;
        id_ready = 1'b1;
        tick();
        chk_state("r3_idle", 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk_state("r3_seq0", 1'b1, 32'd0, 32'd1, 32'd1, 32'd0, 1'b0);
        tick();
        chk_state("r3_seq1", 1'b1, 32'd1, 32'd2, 32'd2, 32'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
